// File: rtl/flog_pkg.sv
// Shared definitions for the floating-point logarithm pipeline controller:
// format defaults, base-conversion constants, FSM and mode encodings.
package flog_pkg;

    localparam int EXP_W_DEF      = 8;
    localparam int MAN_W_DEF      = 7;
    localparam int LOG_FRAC_W_DEF = 16;

    // ln(2) and log10(2) as Q0.32; users take the top LOG_FRAC_W bits (truncated).
    localparam logic [31:0] LN2_Q32     = 32'hB172_17F7;
    localparam logic [31:0] LOG10_2_Q32 = 32'h4D10_4D42;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ITER,
        ST_SCALE,
        ST_NORM,
        ST_OUT
    } state_e;

    typedef enum logic [1:0] {
        MODE_LOG2     = 2'b00,
        MODE_LN       = 2'b01,
        MODE_LOG10    = 2'b10,
        MODE_LOG2_ALT = 2'b11
    } mode_e;

    function automatic int bias_of(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

endpackage

// File: rtl/flog_fx2fp.sv
// Combinational normaliser: unsigned fixed-point magnitude (LOG_FRAC_W fraction
// bits) to biased exponent and truncated mantissa.
module flog_fx2fp
    import flog_pkg::*;
#(
    parameter int EXP_W      = EXP_W_DEF,
    parameter int MAN_W      = MAN_W_DEF,
    parameter int LOG_FRAC_W = LOG_FRAC_W_DEF
) (
    input  logic [EXP_W+LOG_FRAC_W-1:0] mag,
    output logic [EXP_W-1:0]            fp_exp,
    output logic [MAN_W-1:0]            fp_man,
    output logic                        is_zero
);

    localparam int MW   = EXP_W + LOG_FRAC_W;
    localparam int BIAS = bias_of(EXP_W);

    int              pos;
    logic [MW-1:0]   aligned;

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        pos = 0;
        for (int i = 0; i < MW; i++) begin
            if (mag[i]) pos = i;
        end
        is_zero = (mag == '0);
        // Move the leading one to the MSB; the mantissa is the bits right below it.
        aligned = mag << (MW - 1 - pos);
        fp_man  = is_zero ? '0 : MAN_W'(aligned >> (MW - 1 - MAN_W));
        fp_exp  = is_zero ? '0 : EXP_W'(BIAS + pos - LOG_FRAC_W);
    end

endmodule

// File: rtl/flog_pipe_ctrl.sv
// Multi-cycle floating-point logarithm (log2 / ln / log10) with a valid/ready
// handshake: bit-serial log2 of the mantissa, base scaling, then normalisation.
module flog_pipe_ctrl
    import flog_pkg::*;
#(
    parameter int EXP_W      = EXP_W_DEF,
    parameter int MAN_W      = MAN_W_DEF,
    parameter int LOG_FRAC_W = LOG_FRAC_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [EXP_W-1:0] in_exp,
    input  logic [MAN_W-1:0] in_man,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sign,
    output logic [EXP_W-1:0] out_exp,
    output logic [MAN_W-1:0] out_man,
    output logic             flag_invalid,
    output logic             flag_divzero
);

    localparam int BIAS  = bias_of(EXP_W);
    localparam int XW    = EXP_W + LOG_FRAC_W;
    localparam int YF    = MAN_W + LOG_FRAC_W;
    localparam int YW    = YF + 1;
    localparam int CNT_W = $clog2(LOG_FRAC_W + 1);

    localparam logic [EXP_W-1:0]      BIAS_V    = EXP_W'(BIAS);
    localparam logic [LOG_FRAC_W-1:0] LN2_C     = LN2_Q32[31 -: LOG_FRAC_W];
    localparam logic [LOG_FRAC_W-1:0] LOG10_2_C = LOG10_2_Q32[31 -: LOG_FRAC_W];
    localparam logic [MAN_W-1:0]      QNAN_MAN  = {1'b1, {(MAN_W-1){1'b0}}};

    state_e state, state_next;

    logic             is_special;
    logic             sp_sign, sp_inv, sp_dz;
    logic [EXP_W-1:0] sp_exp;
    logic [MAN_W-1:0] sp_man;

    logic [CNT_W-1:0]      cnt;
    logic [YW-1:0]         y, y_next;
    logic [2*YW-1:0]       sq;
    logic                  sq_ge2;
    logic [LOG_FRAC_W-1:0] frac;
    logic [EXP_W-1:0]      e_unb;
    mode_e                 mode_q;

    logic [XW-1:0]            x, x_abs, scaled, mag;
    logic                     x_neg, mag_sign;
    logic [XW+LOG_FRAC_W-1:0] prod;

    logic [EXP_W-1:0] fx_exp;
    logic [MAN_W-1:0] fx_man;
    logic             fx_zero;

    logic             res_sign, res_inv, res_dz;
    logic [EXP_W-1:0] res_exp;
    logic [MAN_W-1:0] res_man;

    // Operand classification; denormals (exp == 0) are flushed to zero.
    always_comb begin
        is_special = 1'b1;
        sp_sign    = 1'b0;
        sp_exp     = '1;
        sp_man     = '0;
        sp_inv     = 1'b0;
        sp_dz      = 1'b0;
        if ((&in_exp) && (in_man != '0)) begin
            sp_man = QNAN_MAN;
            sp_inv = 1'b1;
        end else if (in_exp == '0) begin
            sp_sign = 1'b1;
            sp_dz   = 1'b1;
        end else if (in_sign) begin
            sp_man = QNAN_MAN;
            sp_inv = 1'b1;
        end else if (!(&in_exp)) begin
            is_special = 1'b0;
            sp_exp     = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (in_valid) state_next = is_special ? ST_OUT : ST_ITER;
            ST_ITER:  if (cnt == CNT_W'(LOG_FRAC_W - 1)) state_next = ST_SCALE;
            ST_SCALE: state_next = ST_NORM;
            ST_NORM:  state_next = ST_OUT;
            ST_OUT:   if (out_ready) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready     = (state == ST_IDLE);
        out_valid    = (state == ST_OUT);
        flag_invalid = out_valid & res_inv;
        flag_divzero = out_valid & res_dz;
        out_sign     = res_sign;
        out_exp      = res_exp;
        out_man      = res_man;
    end

    // Squaring step: y in [1,2), y^2 in [1,4); a result >= 2 yields a 1 bit and is halved.
    always_comb begin
        sq     = {{YW{1'b0}}, y} * {{YW{1'b0}}, y};
        sq_ge2 = sq[2*YW-1];
        y_next = sq_ge2 ? YW'(sq >> YW) : YW'(sq >> YF);
    end

    // X = unbiased exponent + log2(1.m), then |X| optionally scaled to ln or log10.
    always_comb begin
        x      = {e_unb, frac};
        x_neg  = x[XW-1];
        x_abs  = x_neg ? (~x + XW'(1)) : x;
        prod   = '0;
        scaled = x_abs;
        case (mode_q)
            MODE_LN: begin
                prod   = {{LOG_FRAC_W{1'b0}}, x_abs} * {{XW{1'b0}}, LN2_C};
                scaled = XW'(prod >> LOG_FRAC_W);
            end
            MODE_LOG10: begin
                prod   = {{LOG_FRAC_W{1'b0}}, x_abs} * {{XW{1'b0}}, LOG10_2_C};
                scaled = XW'(prod >> LOG_FRAC_W);
            end
            default: ;
        endcase
    end

    // NOTE: datapath registers carry no reset; each is loaded on accept before it is read.
    always_ff @(posedge clk) begin
        case (state)
            ST_IDLE: if (in_valid) begin
                e_unb  <= in_exp - BIAS_V;
                y      <= {1'b1, in_man, {LOG_FRAC_W{1'b0}}};
                frac   <= '0;
                cnt    <= '0;
                mode_q <= mode_e'(mode);
            end
            ST_ITER: begin
                y    <= y_next;
                frac <= {frac[LOG_FRAC_W-2:0], sq_ge2};
                cnt  <= cnt + CNT_W'(1);
            end
            ST_SCALE: begin
                mag      <= scaled;
                mag_sign <= x_neg;
            end
            default: ;
        endcase
    end

    flog_fx2fp #(
        .EXP_W      (EXP_W),
        .MAN_W      (MAN_W),
        .LOG_FRAC_W (LOG_FRAC_W)
    ) u_fx2fp (
        .mag     (mag),
        .fp_exp  (fx_exp),
        .fp_man  (fx_man),
        .is_zero (fx_zero)
    );

    // Result registers are only written on accept or leaving NORM, so they hold through OUT.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_sign <= 1'b0;
            res_exp  <= '0;
            res_man  <= '0;
            res_inv  <= 1'b0;
            res_dz   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (in_valid) begin
                    res_sign <= sp_sign;
                    res_exp  <= sp_exp;
                    res_man  <= sp_man;
                    res_inv  <= sp_inv;
                    res_dz   <= sp_dz;
                end
                ST_NORM: begin
                    res_sign <= mag_sign & ~fx_zero;
                    res_exp  <= fx_exp;
                    res_man  <= fx_man;
                    res_inv  <= 1'b0;
                    res_dz   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_flog_pipe_ctrl.sv
// Directed bench for flog_pipe_ctrl at default widths (8-bit exp, 7-bit mantissa):
// a vector table for results/flags/latency plus backpressure and reset sequences.
module tb_flog_pipe_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic       in_sign;
    logic [7:0] in_exp;
    logic [6:0] in_man;
    logic [1:0] mode;
    logic       out_valid;
    logic       out_ready;
    logic       out_sign;
    logic [7:0] out_exp;
    logic [6:0] out_man;
    logic       flag_invalid;
    logic       flag_divzero;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] op;
        logic [1:0]  md;
        logic [15:0] want;
        logic        inv;
        logic        dz;
        int          lat;
    } vec_t;

    vec_t vecs[20];

    flog_pipe_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sign      (in_sign),
        .in_exp       (in_exp),
        .in_man       (in_man),
        .mode         (mode),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sign     (out_sign),
        .out_exp      (out_exp),
        .out_man      (out_man),
        .flag_invalid (flag_invalid),
        .flag_divzero (flag_divzero)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic logic [15:0] result();
        return {out_sign, out_exp, out_man};
    endfunction

    // Presents an operand and returns at the negedge one cycle after it was accepted.
    task automatic issue(input logic [15:0] op, input logic [1:0] md);
        int n = 0;
        @(negedge clk);
        {in_sign, in_exp, in_man} = op;
        mode     = md;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Latency in cycles counted from the accept cycle; bounded.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int seen;

        vecs[0]  = '{16'h3F80, 2'd0, 16'h0000, 1'b0, 1'b0, 19};
        vecs[1]  = '{16'h4000, 2'd0, 16'h3F80, 1'b0, 1'b0, 19};
        vecs[2]  = '{16'h3F00, 2'd0, 16'hBF80, 1'b0, 1'b0, 19};
        vecs[3]  = '{16'h4100, 2'd0, 16'h4040, 1'b0, 1'b0, 19};
        vecs[4]  = '{16'h4000, 2'd1, 16'h3F31, 1'b0, 1'b0, 19};
        vecs[5]  = '{16'h4000, 2'd2, 16'h3E9A, 1'b0, 1'b0, 19};
        vecs[6]  = '{16'h4000, 2'd3, 16'h3F80, 1'b0, 1'b0, 19};
        vecs[7]  = '{16'h3F00, 2'd1, 16'hBF31, 1'b0, 1'b0, 19};
        vecs[8]  = '{16'h4100, 2'd1, 16'h4005, 1'b0, 1'b0, 19};
        vecs[9]  = '{16'h4040, 2'd0, 16'h3FCA, 1'b0, 1'b0, 19};
        vecs[10] = '{16'h3F40, 2'd0, 16'hBED4, 1'b0, 1'b0, 19};
        vecs[11] = '{16'h0000, 2'd0, 16'hFF80, 1'b0, 1'b1, 1};
        vecs[12] = '{16'h8000, 2'd0, 16'hFF80, 1'b0, 1'b1, 1};
        vecs[13] = '{16'h0001, 2'd0, 16'hFF80, 1'b0, 1'b1, 1};
        vecs[14] = '{16'hBF80, 2'd0, 16'h7FC0, 1'b1, 1'b0, 1};
        vecs[15] = '{16'h7F80, 2'd0, 16'h7F80, 1'b0, 1'b0, 1};
        vecs[16] = '{16'hFFC0, 2'd0, 16'h7FC0, 1'b1, 1'b0, 1};
        vecs[17] = '{16'hFF80, 2'd0, 16'h7FC0, 1'b1, 1'b0, 1};
        vecs[18] = '{16'h7F81, 2'd0, 16'h7FC0, 1'b1, 1'b0, 1};
        vecs[19] = '{16'h0000, 2'd1, 16'hFF80, 1'b0, 1'b1, 1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_exp    = '0;
        in_man    = '0;
        mode      = 2'd0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_result", 32'(result()), 32'd0);
        check("reset_flags", 32'({flag_invalid, flag_divzero}), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            issue(vecs[i].op, vecs[i].md);
            wait_valid(lat);
            check($sformatf("v%0d_%h_latency", i, vecs[i].op), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("v%0d_%h_result", i, vecs[i].op), 32'(result()), 32'(vecs[i].want));
            check($sformatf("v%0d_%h_invalid", i, vecs[i].op), 32'(flag_invalid), 32'(vecs[i].inv));
            check($sformatf("v%0d_%h_divzero", i, vecs[i].op), 32'(flag_divzero), 32'(vecs[i].dz));
            check($sformatf("v%0d_in_ready_in_out", i), 32'(in_ready), 32'd0);
            drain();
        end

        // Backpressure: hold out_ready low with another operand pending.
        issue(16'h4000, 2'd0);
        wait_valid(lat);
        check("bp_latency", 32'(lat), 32'd19);
        {in_sign, in_exp, in_man} = 16'h0000;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp%0d_result", k), 32'(result()), 32'h3F80);
            check($sformatf("bp%0d_valid_ready", k), 32'({out_valid, in_ready}), 32'b10);
            check($sformatf("bp%0d_flags", k), 32'({flag_invalid, flag_divzero}), 32'd0);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_release_valid_ready", 32'({out_valid, in_ready}), 32'b01);

        // Flags must drop outside OUT; then reset mid-ITER discards the operation.
        issue(16'h0000, 2'd0);
        wait_valid(lat);
        check("pre_dz_flag", 32'(flag_divzero), 32'd1);
        drain();
        issue(16'h3F80, 2'd0);
        repeat (4) @(negedge clk);
        check("iter_flags_low", 32'({flag_invalid, flag_divzero}), 32'd0);
        check("iter_valid_ready", 32'({out_valid, in_ready}), 32'b00);
        rst = 1'b1;
        @(negedge clk);
        check("rst_iter_valid_ready", 32'({out_valid, in_ready}), 32'b01);
        rst  = 1'b0;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("rst_iter_no_valid", 32'(seen), 32'd0);
        issue(16'h4000, 2'd0);
        wait_valid(lat);
        check("post_rst_latency", 32'(lat), 32'd19);
        check("post_rst_result", 32'(result()), 32'h3F80);
        drain();

        // Reset while OUT is held.
        issue(16'hBF80, 2'd0);
        wait_valid(lat);
        check("pre_rst_out_invalid", 32'(flag_invalid), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_out_valid_ready", 32'({out_valid, in_ready}), 32'b01);
        check("rst_out_result", 32'(result()), 32'd0);
        check("rst_out_flags", 32'({flag_invalid, flag_divzero}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
